// File: rtl/lab3_mem_line_word_adapter.sv
// Splits one 16B cache-line request into four 4B word transactions and reassembles one 16B response.
// Optional build macro LAB3_MEM_LINE_WORD_ADAPTER_BYPASS_EN returns the line in the cycle the last word arrives.
module lab3_mem_line_word_adapter #(
  parameter bit p_opq_check = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  // {type[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
  input  logic [174:0] linereq_msg,
  input  logic         linereq_val,
  output logic         linereq_rdy,
  // {type[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
  output logic [144:0] lineresp_msg,
  output logic         lineresp_val,
  input  logic         lineresp_rdy,
  // {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
  output logic [76:0]  wordreq_msg,
  output logic         wordreq_val,
  input  logic         wordreq_rdy,
  // {type[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
  input  logic [46:0]  wordresp_msg,
  input  logic         wordresp_val,
  output logic         wordresp_rdy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] COLLECT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [2:0] TYPE_READ = 3'd0;

  logic [1:0]       state, state_next;
  logic [2:0]       line_type;
  logic [7:0]       line_opaque;
  logic [31:0]      line_addr;
  logic [127:0]     line_data;
  logic [2:0]       issue_cnt;
  logic [2:0]       resp_cnt, resp_cnt_next;
  logic [3:0]       slot_mask;
  logic [3:0][31:0] word_buf, resp_words;
  logic [1:0]       resp_slot;
  logic             is_read;
  logic             linereq_go, wordreq_go, wordresp_go, lineresp_go;
  logic             last_issue, resp_done, bypass_hit;
  logic             unused_bits;

  assign is_read       = (line_type == TYPE_READ);
  assign resp_slot     = p_opq_check ? wordresp_msg[37:36] : resp_cnt[1:0];
  assign linereq_go    = linereq_val && linereq_rdy;
  assign wordreq_go    = wordreq_val && wordreq_rdy;
  assign wordresp_go   = wordresp_val && wordresp_rdy;
  assign lineresp_go   = lineresp_val && lineresp_rdy;
  assign last_issue    = wordreq_go && (issue_cnt == 3'd3);
  assign resp_cnt_next = resp_cnt + {2'b00, wordresp_go};
  assign resp_done     = resp_cnt_next[2];

`ifdef LAB3_MEM_LINE_WORD_ADAPTER_BYPASS_EN
  assign bypass_hit = (state == COLLECT) && wordresp_val && (resp_cnt == 3'd3);
`else
  assign bypass_hit = 1'b0;
`endif

  // In a bypass cycle the final word is only taken together with the line response.
  always_comb begin
    linereq_rdy  = 1'b0;
    wordreq_val  = 1'b0;
    wordresp_rdy = 1'b0;
    lineresp_val = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    linereq_rdy = 1'b1;
        ISSUE: begin
          wordreq_val  = 1'b1;
          wordresp_rdy = 1'b1;
        end
        COLLECT: begin
          wordresp_rdy = bypass_hit ? lineresp_rdy : 1'b1;
          lineresp_val = bypass_hit;
        end
        default: lineresp_val = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (linereq_go) state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = resp_done ? RESP : COLLECT;
      COLLECT: begin
        if (bypass_hit && lineresp_go) state_next = IDLE;
        else if (resp_done)            state_next = RESP;
      end
      default: if (lineresp_go) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      issue_cnt <= 3'd0;
      resp_cnt  <= 3'd0;
      slot_mask <= 4'd0;
    end else begin
      state <= state_next;
      if (linereq_go) begin
        issue_cnt <= 3'd0;
        resp_cnt  <= 3'd0;
        slot_mask <= 4'd0;
      end else begin
        if (wordreq_go) issue_cnt <= issue_cnt + 3'd1;
        if (wordresp_go) begin
          resp_cnt             <= resp_cnt_next;
          slot_mask[resp_slot] <= 1'b1;
        end
      end
    end
  end

  // Line fields and word buffer are always reloaded before use; a repeated slot keeps its first word.
  always_ff @(posedge clk) begin
    if (linereq_go) begin
      line_type   <= linereq_msg[174:172];
      line_opaque <= linereq_msg[171:164];
      line_addr   <= {linereq_msg[163:136], 4'b0000};
      line_data   <= linereq_msg[127:0];
    end
    if (wordresp_go && is_read && !slot_mask[resp_slot])
      word_buf[resp_slot] <= wordresp_msg[31:0];
  end

  always_comb begin
    resp_words = word_buf;
    if (bypass_hit) resp_words[resp_slot] = wordresp_msg[31:0];
  end

  assign wordreq_msg = {line_type, 6'b000000, issue_cnt[1:0],
                        line_addr + {28'd0, issue_cnt[1:0], 2'b00}, 2'b00,
                        is_read ? 32'd0 : line_data[{issue_cnt[1:0], 5'd0} +: 32]};

  assign lineresp_msg = {line_type, line_opaque, 2'b00, 4'b0000,
                         is_read ? 128'(resp_words) : 128'd0};

  assign unused_bits = ^{linereq_msg[135:128], wordresp_msg[46:38], wordresp_msg[35:32]};

endmodule

// File: tb/tb_lab3_mem_line_word_adapter.sv
// Directed bench for lab3_mem_line_word_adapter with a small word-memory responder.
module tb_lab3_mem_line_word_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic [174:0] linereq_msg;
  logic         linereq_val;
  logic         linereq_rdy;
  logic [144:0] lineresp_msg;
  logic         lineresp_val;
  logic         lineresp_rdy;
  logic [76:0]  wordreq_msg;
  logic         wordreq_val;
  logic         wordreq_rdy;
  logic [46:0]  wordresp_msg = '0;
  logic         wordresp_val = 1'b0;
  logic         wordresp_rdy;

  int checks = 0;
  int errors = 0;

`ifdef LAB3_MEM_LINE_WORD_ADAPTER_BYPASS_EN
  localparam int          LAT     = 5;
  localparam logic [8:0]  T1_RDY  = 9'h1C0;
  localparam logic [8:0]  T1_LRV  = 9'h020;
  localparam logic [14:0] T6_RDY  = 15'h1041;
  localparam logic [14:0] T6_FIRE = 15'h0820;
`else
  localparam int          LAT     = 6;
  localparam logic [8:0]  T1_RDY  = 9'h180;
  localparam logic [8:0]  T1_LRV  = 9'h040;
  localparam logic [14:0] T6_RDY  = 15'h4081;
  localparam logic [14:0] T6_FIRE = 15'h2040;
`endif

  lab3_mem_line_word_adapter dut (
    .clk          (clk),
    .reset        (reset),
    .linereq_msg  (linereq_msg),
    .linereq_val  (linereq_val),
    .linereq_rdy  (linereq_rdy),
    .lineresp_msg (lineresp_msg),
    .lineresp_val (lineresp_val),
    .lineresp_rdy (lineresp_rdy),
    .wordreq_msg  (wordreq_msg),
    .wordreq_val  (wordreq_val),
    .wordreq_rdy  (wordreq_rdy),
    .wordresp_msg (wordresp_msg),
    .wordresp_val (wordresp_val),
    .wordresp_rdy (wordresp_rdy)
  );

  always #5 clk = ~clk;

  // Word memory: in-order one-cycle responder (mode 0) or hold-four-then-release in order[] (mode 1).
  logic [76:0] req_q[$];
  logic [76:0] req_log[$];
  logic [31:0] mem [logic [31:0]];
  int          mem_mode = 0;
  int          ridx = 0;
  int          order[4];
  logic        m_rst, m_req_fire, m_resp_fire;
  logic [76:0] m_req, m_cur;
  logic [31:0] m_rdata;

  always begin
    @(negedge clk);
    m_rst       = reset;
    m_req_fire  = wordreq_val && wordreq_rdy;
    m_resp_fire = wordresp_val && wordresp_rdy;
    m_req       = wordreq_msg;
    @(posedge clk);
    #1;
    if (m_rst) begin
      req_q.delete();
      ridx = 0;
    end else begin
      if (m_resp_fire) begin
        if (mem_mode == 0) void'(req_q.pop_front());
        else begin
          ridx++;
          if (ridx == 4) begin
            req_q.delete();
            ridx = 0;
          end
        end
      end
      if (m_req_fire) begin
        req_q.push_back(m_req);
        req_log.push_back(m_req);
        if (m_req[76:74] == 3'd1) mem[m_req[65:34]] = m_req[31:0];
      end
    end
    wordresp_val = 1'b0;
    if ((mem_mode == 0 && req_q.size() > 0) || (mem_mode == 1 && req_q.size() == 4)) begin
      m_cur   = (mem_mode == 0) ? req_q[0] : req_q[order[ridx]];
      m_rdata = 32'd0;
      if (m_cur[76:74] == 3'd0 && mem.exists(m_cur[65:34])) m_rdata = mem[m_cur[65:34]];
      wordresp_msg = {m_cur[76:74], m_cur[73:66], 2'b00, 2'b00, m_rdata};
      wordresp_val = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [191:0] observed, input logic [191:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [174:0] mkLineReq(input logic [2:0] t, input logic [7:0] opq,
                                             input logic [31:0] addr, input logic [127:0] data);
    return {t, opq, addr, 4'b0000, data};
  endfunction

  // Presents one line request for a single cycle; the adapter must be idle.
  task automatic applyStimulus(input logic [2:0] t, input logic [7:0] opq,
                               input logic [31:0] addr, input logic [127:0] data);
    linereq_msg = mkLineReq(t, opq, addr, data);
    linereq_val = 1'b1;
    @(posedge clk);
    #1;
    linereq_val = 1'b0;
  endtask

  logic [144:0] resp_seen;

  task automatic waitLineResp(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (lineresp_val && lineresp_rdy) begin
        got       = 1'b1;
        resp_seen = lineresp_msg;
      end
      @(posedge clk);
      #1;
    end
    checkOutput(tag, got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [8:0]   t1_lrv, t1_wqv, t1_rdy;
  logic [144:0] t1_msg, held_msg, r0, r1;
  logic [127:0] wdata;
  logic [3:0]   pat;
  logic         done, stable_bad, rdy_seen, acc;
  int           held, nacc, nresp;
  logic [14:0]  t6_rdy, t6_fire;

  initial begin
    reset        = 1'b1;
    linereq_val  = 1'b0;
    linereq_msg  = '0;
    wordreq_rdy  = 1'b1;
    lineresp_rdy = 1'b1;
    order[0] = 3; order[1] = 1; order[2] = 0; order[3] = 2;
    for (int k = 0; k < 4; k++) begin
      mem[32'h1000 + 4 * k] = 32'hA0 + k;
      mem[32'h3000 + 4 * k] = 32'hB0 + k;
      mem[32'h4000 + 4 * k] = 32'hC0 + k;
    end

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_handshakes", {linereq_rdy, wordreq_val, wordresp_rdy, lineresp_val}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", {linereq_rdy, wordreq_val, wordresp_rdy, lineresp_val}, 4'b1000);
    @(posedge clk);
    #1;

    // Zero-wait read with unaligned address
    req_log.delete();
    applyStimulus(3'd0, 8'h11, 32'h0000_1004, 128'd0);
    t1_lrv = '0; t1_wqv = '0; t1_rdy = '0; t1_msg = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      t1_lrv[c] = lineresp_val;
      t1_wqv[c] = wordreq_val;
      t1_rdy[c] = linereq_rdy;
      if (c == LAT) t1_msg = lineresp_msg;
      @(posedge clk);
      #1;
    end
    checkOutput("t1_lineresp_val_timing", t1_lrv, T1_LRV);
    checkOutput("t1_wordreq_val_timing", t1_wqv, 9'h01E);
    checkOutput("t1_linereq_rdy_timing", t1_rdy, T1_RDY);
    checkOutput("t1_lineresp_msg", t1_msg,
                {3'd0, 8'h11, 2'b00, 4'h0, 128'h000000A3_000000A2_000000A1_000000A0});
    checkOutput("t1_nreq", req_log.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t1_wordreq%0d", k), req_log[k],
                  {3'd0, 6'd0, 2'(k), 32'h1000 + 32'(4 * k), 2'b00, 32'd0});

    // Line write
    req_log.delete();
    wdata = 128'h44444444_33333333_22222222_11111111;
    applyStimulus(3'd1, 8'h22, 32'h0000_2000, wdata);
    waitLineResp("t2_timeout", 20);
    checkOutput("t2_lineresp_msg", resp_seen, {3'd1, 8'h22, 2'b00, 4'h0, 128'd0});
    checkOutput("t2_nreq", req_log.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t2_wordreq%0d", k), req_log[k],
                  {3'd1, 6'd0, 2'(k), 32'h2000 + 32'(4 * k), 2'b00, wdata[32 * k +: 32]});
    checkOutput("t2_mem", {mem[32'h200C], mem[32'h2008], mem[32'h2004], mem[32'h2000]}, wdata);

    // Out-of-order word responses 3,1,0,2
    mem_mode = 1;
    applyStimulus(3'd0, 8'h33, 32'h0000_3000, 128'd0);
    waitLineResp("t3_timeout", 30);
    checkOutput("t3_lineresp_msg", resp_seen,
                {3'd0, 8'h33, 2'b00, 4'h0, 128'h000000B3_000000B2_000000B1_000000B0});
    mem_mode = 0;

    // Back-pressure on word requests and on the line response
    req_log.delete();
    lineresp_rdy = 1'b0;
    pat = 4'b1001;
    applyStimulus(3'd0, 8'h44, 32'h0000_4008, 128'd0);
    done = 1'b0; stable_bad = 1'b0; rdy_seen = 1'b0; held = 0; held_msg = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      wordreq_rdy = pat[c % 4];
      @(negedge clk);
      if (linereq_rdy) rdy_seen = 1'b1;
      if (lineresp_val) begin
        if (held == 0) held_msg = lineresp_msg;
        else if (lineresp_msg !== held_msg) stable_bad = 1'b1;
        held++;
        if (lineresp_rdy) done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (held >= 3) lineresp_rdy = 1'b1;
    end
    wordreq_rdy  = 1'b1;
    lineresp_rdy = 1'b1;
    checkOutput("t4_done", done, 1'b1);
    checkOutput("t4_resp_cycles", held, 4);
    checkOutput("t4_msg_stable", stable_bad, 1'b0);
    checkOutput("t4_linereq_rdy_busy", rdy_seen, 1'b0);
    checkOutput("t4_lineresp_msg", held_msg,
                {3'd0, 8'h44, 2'b00, 4'h0, 128'h000000C3_000000C2_000000C1_000000C0});
    checkOutput("t4_word_addrs", {req_log.size(), req_log[0][65:34], req_log[1][65:34],
                                  req_log[2][65:34], req_log[3][65:34]},
                {32'd4, 32'h4000, 32'h4004, 32'h4008, 32'h400C});

    // Reset in the middle of a line
    req_log.delete();
    applyStimulus(3'd0, 8'h55, 32'h0000_5000, 128'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_handshakes", {linereq_rdy, wordreq_val, wordresp_rdy, lineresp_val}, 4'b0000);
    checkOutput("t5_words_before_rst", req_log.size(), 2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_post_rst_idle", {linereq_rdy, wordreq_val, wordresp_rdy, lineresp_val}, 4'b1000);
    @(posedge clk);
    #1;
    applyStimulus(3'd0, 8'h56, 32'h0000_1000, 128'd0);
    waitLineResp("t5_timeout", 20);
    checkOutput("t5_lineresp_msg", resp_seen,
                {3'd0, 8'h56, 2'b00, 4'h0, 128'h000000A3_000000A2_000000A1_000000A0});

    // Back-to-back lines with linereq_val held high
    linereq_msg = mkLineReq(3'd0, 8'h61, 32'h0000_1000, 128'd0);
    linereq_val = 1'b1;
    t6_rdy = '0; t6_fire = '0; nacc = 0; nresp = 0; r0 = '0; r1 = '0;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      t6_rdy[c] = linereq_rdy;
      acc = linereq_val && linereq_rdy;
      if (lineresp_val && lineresp_rdy) begin
        t6_fire[c] = 1'b1;
        if (nresp == 0) r0 = lineresp_msg;
        else r1 = lineresp_msg;
        nresp++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        if (nacc == 1) linereq_msg = mkLineReq(3'd0, 8'h62, 32'h0000_3000, 128'd0);
        else linereq_val = 1'b0;
      end
    end
    checkOutput("t6_linereq_rdy_timing", t6_rdy, T6_RDY);
    checkOutput("t6_lineresp_fire_timing", t6_fire, T6_FIRE);
    checkOutput("t6_first_resp", r0,
                {3'd0, 8'h61, 2'b00, 4'h0, 128'h000000A3_000000A2_000000A1_000000A0});
    checkOutput("t6_second_resp", r1,
                {3'd0, 8'h62, 2'b00, 4'h0, 128'h000000B3_000000B2_000000B1_000000B0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
